ren_dispatch_ctrl: RTL and testbench

- Controller for the rename stage.
- Decides each cycle whether the head instruction of the decode-rename queue may be popped, renamed and dispatched. The decision depends on IQ/LSQ/ROB/free-list availability.
- Drives the registered push strobes to IQ, LSQ and ROB.
- On a ROB flush, sequences recovery:
  - overwrites the rename RAT from the retirement RAT;
  - flushes the free list;
  - rebuilds the free list by walking all physical registers.

---
 rtl/ren_pkg.sv | 21 ++
 rtl/freel_rebuild_walker.sv | 62 ++++++
 rtl/ren_dispatch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ren_dispatch_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ren_pkg.sv
// Shared definitions for the rename/dispatch controller: state encoding,
// stall-cause bit positions and default physical register file geometry.
package ren_pkg;

  localparam int REN_PHYS_ADDRWIDTH = 6;
  localparam int REN_NUM_PHYSREGS   = 1 << REN_PHYS_ADDRWIDTH;

  // Bit positions inside the 4-bit stall-cause vector.
  localparam int REN_STALL_IQ    = 0;
  localparam int REN_STALL_LSQ   = 1;
  localparam int REN_STALL_ROB   = 2;
  localparam int REN_STALL_FREEL = 3;

  typedef enum logic [1:0] {
    REN_IDLE      = 2'd0,
    REN_RATCOPY   = 2'd1,
    REN_FLREBUILD = 2'd2,
    REN_DONE      = 2'd3
  } ren_state_e;

endpackage

// File: rtl/freel_rebuild_walker.sv
// Walks physical registers 1..NUM_PHYSREGS-1 after a flush and pushes every
// register not referenced by the retirement RAT back onto the free list.
// Register 0 is the hardwired zero register and is never pushed.
module freel_rebuild_walker
  import ren_pkg::*;
#(
  parameter int PHYS_ADDRWIDTH = REN_PHYS_ADDRWIDTH,
  parameter int NUM_PHYSREGS   = REN_NUM_PHYSREGS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_PHYSREGS-1:0]   fArchMapped_IN,
  output logic                      pushReq,
  output logic [PHYS_ADDRWIDTH-1:0] pushData,
  output logic                      done
);

  localparam logic [PHYS_ADDRWIDTH-1:0] LAST_IDX = PHYS_ADDRWIDTH'(NUM_PHYSREGS - 1);

  logic [PHYS_ADDRWIDTH-1:0] idx_q, idx_d;
  logic                      active_q, active_d;

  // Push generation and the last-index flag, decoded from the current index.
  always_comb begin
    pushReq  = active_q & ~fArchMapped_IN[idx_q];
    pushData = pushReq ? idx_q : '0;
    done     = active_q & (idx_q == LAST_IDX);
  end

  // Next index: load 1 on start, step while active, stop (no wrap) on the last index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    idx_d    = idx_q;
    active_d = active_q;
    if (start) begin
      idx_d    = PHYS_ADDRWIDTH'(1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (done) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + PHYS_ADDRWIDTH'(1);
      end
    end
  end

  // Walker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (!rst_n) begin
      idx_q    <= '0;
      active_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ren_dispatch_ctrl.sv
// Rename-stage controller: decides per cycle whether the decode-rename queue
// head is renamed and dispatched, drives registered IQ/LSQ/ROB push strobes,
// tracks stall causes, and sequences RAT/free-list recovery after a ROB flush.
module ren_dispatch_ctrl
  import ren_pkg::*;
#(
  parameter int PHYS_ADDRWIDTH  = REN_PHYS_ADDRWIDTH,
  parameter int NUM_PHYSREGS    = REN_NUM_PHYSREGS,
  parameter int STALL_CTR_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FREEZE,
  input  logic                       fQ_IDREN_empty_IN,
  input  logic                       fQ_IDREN_isMem_IN,
  input  logic                       fQ_IDREN_destReqd_IN,
  output logic                       tQ_IDREN_popReq_OUT,
  input  logic                       fIQ_full_IN,
  input  logic                       fLSQ_full_IN,
  input  logic                       fROB_full_IN,
  input  logic                       fFreeL_empty_IN,
  output logic                       tFreeL_popReq_OUT,
  output logic                       tRenRat_wrEn_OUT,
  output logic                       tIQ_pushReq_OUT,
  output logic                       tLSQ_pushReq_OUT,
  output logic                       tROB_pushReq_OUT,
  input  logic                       fROB_flushReq_IN,
  output logic                       tROB_flushAck_OUT,
  input  logic [NUM_PHYSREGS-1:0]    fArchMapped_IN,
  output logic                       tRenRatOverwrite_OUT,
  output logic                       tFreeL_flush_OUT,
  output logic                       tFreeL_pushReq_OUT,
  output logic [PHYS_ADDRWIDTH-1:0]  tFreeL_pushData_OUT,
  output logic [3:0]                 tStallCause_OUT,
  output logic [STALL_CTR_WIDTH-1:0] tStallCycles_OUT,
  output logic                       tBusy_OUT
);

  ren_state_e state_q, state_d;
  logic overwrite_q, overwrite_d;
  logic fl_flush_q, fl_flush_d;
  logic ack_q, ack_d;
  logic busy_q, busy_d;
  logic iq_push_q, iq_push_d;
  logic lsq_push_q, lsq_push_d;
  logic rob_push_q, rob_push_d;
  logic [3:0] cause_q, cause_d;
  logic [STALL_CTR_WIDTH-1:0] stall_cycles_q, stall_cycles_d;

  logic is_idle;
  logic have_instr;
  logic queue_ok;
  logic freel_ok;
  logic go;
  logic walk_start;
  logic walk_done;

  // Dispatch decision for the queue head; a flush request always wins.
  // The reset term keeps the combinational strobes quiet while reset is held.
  always_comb begin
    is_idle    = (state_q == REN_IDLE);
    have_instr = is_idle & ~FREEZE & ~fQ_IDREN_empty_IN;
    queue_ok   = fQ_IDREN_isMem_IN ? ~fLSQ_full_IN : ~fIQ_full_IN;
    freel_ok   = ~fQ_IDREN_destReqd_IN | ~fFreeL_empty_IN;
    go         = RESET & have_instr & ~fROB_flushReq_IN & ~fROB_full_IN
               & queue_ok & freel_ok;

    tQ_IDREN_popReq_OUT = go;
    tFreeL_popReq_OUT   = go & fQ_IDREN_destReqd_IN;
    tRenRat_wrEn_OUT    = go & fQ_IDREN_destReqd_IN;

    iq_push_d  = go & ~fQ_IDREN_isMem_IN;
    lsq_push_d = go & fQ_IDREN_isMem_IN;
    rob_push_d = go;
  end

  // Stall causes are sampled only while an instruction is waiting in IDLE;
  // the counter accumulates any blocked cycle and saturates.
  always_comb begin
    cause_d = '0;
    if (have_instr) begin
      cause_d[REN_STALL_IQ]    = ~fQ_IDREN_isMem_IN & fIQ_full_IN;
      cause_d[REN_STALL_LSQ]   = fQ_IDREN_isMem_IN & fLSQ_full_IN;
      cause_d[REN_STALL_ROB]   = fROB_full_IN;
      cause_d[REN_STALL_FREEL] = fQ_IDREN_destReqd_IN & fFreeL_empty_IN;
    end
    stall_cycles_d = stall_cycles_q;
    if ((|cause_d) && (stall_cycles_q != {STALL_CTR_WIDTH{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + STALL_CTR_WIDTH'(1);
    end
  end

  // Recovery sequencer next state and its registered outputs.
  always_comb begin
    state_d     = state_q;
    overwrite_d = 1'b0;
    fl_flush_d  = 1'b0;
    ack_d       = 1'b0;
    unique case (state_q)
      REN_IDLE: begin
        if (fROB_flushReq_IN) begin
          state_d     = REN_RATCOPY;
          overwrite_d = 1'b1;
          fl_flush_d  = 1'b1;
        end
      end
      REN_RATCOPY: state_d = REN_FLREBUILD;
      REN_FLREBUILD: begin
        if (walk_done) begin
          state_d = REN_DONE;
          ack_d   = 1'b1;
        end
      end
      REN_DONE: state_d = REN_IDLE;
      default: state_d = REN_IDLE;
    endcase
    busy_d = (state_d != REN_IDLE);
  end

  assign walk_start = (state_q == REN_RATCOPY);

  freel_rebuild_walker #(
    .PHYS_ADDRWIDTH(PHYS_ADDRWIDTH),
    .NUM_PHYSREGS  (NUM_PHYSREGS)
  ) u_walker (
    .clk           (CLK),
    .rst_n         (RESET),
    .start         (walk_start),
    .fArchMapped_IN(fArchMapped_IN),
    .pushReq       (tFreeL_pushReq_OUT),
    .pushData      (tFreeL_pushData_OUT),
    .done          (walk_done)
  );

  // FSM state, recovery strobes, push strobes and stall tracking registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q        <= REN_IDLE;
      overwrite_q    <= 1'b0;
      fl_flush_q     <= 1'b0;
      ack_q          <= 1'b0;
      busy_q         <= 1'b0;
      iq_push_q      <= 1'b0;
      lsq_push_q     <= 1'b0;
      rob_push_q     <= 1'b0;
      cause_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      overwrite_q    <= overwrite_d;
      fl_flush_q     <= fl_flush_d;
      ack_q          <= ack_d;
      busy_q         <= busy_d;
      iq_push_q      <= iq_push_d;
      lsq_push_q     <= lsq_push_d;
      rob_push_q     <= rob_push_d;
      cause_q        <= cause_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign tRenRatOverwrite_OUT = overwrite_q;
  assign tFreeL_flush_OUT     = fl_flush_q;
  assign tROB_flushAck_OUT    = ack_q;
  assign tBusy_OUT            = busy_q;
  assign tIQ_pushReq_OUT      = iq_push_q;
  assign tLSQ_pushReq_OUT     = lsq_push_q;
  assign tROB_pushReq_OUT     = rob_push_q;
  assign tStallCause_OUT      = cause_q;
  assign tStallCycles_OUT     = stall_cycles_q;

endmodule

// File: tb/tb_ren_dispatch_ctrl.sv
// Directed bench for ren_dispatch_ctrl: dispatch, stalls, freeze, flush
// recovery timing and reset abort, all against hand-computed expectations.
module tb_ren_dispatch_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FREEZE;
  logic        fQ_IDREN_empty_IN, fQ_IDREN_isMem_IN, fQ_IDREN_destReqd_IN;
  logic        tQ_IDREN_popReq_OUT;
  logic        fIQ_full_IN, fLSQ_full_IN, fROB_full_IN, fFreeL_empty_IN;
  logic        tFreeL_popReq_OUT, tRenRat_wrEn_OUT;
  logic        tIQ_pushReq_OUT, tLSQ_pushReq_OUT, tROB_pushReq_OUT;
  logic        fROB_flushReq_IN, tROB_flushAck_OUT;
  logic [63:0] fArchMapped_IN;
  logic        tRenRatOverwrite_OUT, tFreeL_flush_OUT, tFreeL_pushReq_OUT;
  logic [5:0]  tFreeL_pushData_OUT;
  logic [3:0]  tStallCause_OUT;
  logic [15:0] tStallCycles_OUT;
  logic        tBusy_OUT;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks;

  ren_dispatch_ctrl dut (
    .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
    .fQ_IDREN_empty_IN(fQ_IDREN_empty_IN), .fQ_IDREN_isMem_IN(fQ_IDREN_isMem_IN),
    .fQ_IDREN_destReqd_IN(fQ_IDREN_destReqd_IN), .tQ_IDREN_popReq_OUT(tQ_IDREN_popReq_OUT),
    .fIQ_full_IN(fIQ_full_IN), .fLSQ_full_IN(fLSQ_full_IN), .fROB_full_IN(fROB_full_IN),
    .fFreeL_empty_IN(fFreeL_empty_IN), .tFreeL_popReq_OUT(tFreeL_popReq_OUT),
    .tRenRat_wrEn_OUT(tRenRat_wrEn_OUT), .tIQ_pushReq_OUT(tIQ_pushReq_OUT),
    .tLSQ_pushReq_OUT(tLSQ_pushReq_OUT), .tROB_pushReq_OUT(tROB_pushReq_OUT),
    .fROB_flushReq_IN(fROB_flushReq_IN), .tROB_flushAck_OUT(tROB_flushAck_OUT),
    .fArchMapped_IN(fArchMapped_IN), .tRenRatOverwrite_OUT(tRenRatOverwrite_OUT),
    .tFreeL_flush_OUT(tFreeL_flush_OUT), .tFreeL_pushReq_OUT(tFreeL_pushReq_OUT),
    .tFreeL_pushData_OUT(tFreeL_pushData_OUT), .tStallCause_OUT(tStallCause_OUT),
    .tStallCycles_OUT(tStallCycles_OUT), .tBusy_OUT(tBusy_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are changed and outputs sampled 2 ns after the edge.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Every output packed together so "all zero" is one comparison.
  function automatic logic [63:0] all_outs();
    return {tQ_IDREN_popReq_OUT, tFreeL_popReq_OUT, tRenRat_wrEn_OUT, tIQ_pushReq_OUT,
            tLSQ_pushReq_OUT, tROB_pushReq_OUT, tROB_flushAck_OUT, tRenRatOverwrite_OUT,
            tFreeL_flush_OUT, tFreeL_pushReq_OUT, tFreeL_pushData_OUT, tStallCause_OUT,
            tStallCycles_OUT, tBusy_OUT};
  endfunction

  task automatic set_instr(input logic empty, input logic is_mem, input logic dest);
    fQ_IDREN_empty_IN = empty;
    fQ_IDREN_isMem_IN = is_mem;
    fQ_IDREN_destReqd_IN = dest;
  endtask

  initial begin
    RESET = 1'b0; FREEZE = 1'b0;
    set_instr(1'b1, 1'b0, 1'b0);
    fIQ_full_IN = 1'b0; fLSQ_full_IN = 1'b0; fROB_full_IN = 1'b0; fFreeL_empty_IN = 1'b0;
    fROB_flushReq_IN = 1'b0; fArchMapped_IN = '0;
    tick(); tick();
    check("reset_outs", all_outs(), 64'h0);
    RESET = 1'b1;
    tick();

    // ALU instruction with a destination, everything free.
    set_instr(1'b0, 1'b0, 1'b1); #1;
    check("alu_pop", tQ_IDREN_popReq_OUT, 1);
    check("alu_flpop", tFreeL_popReq_OUT, 1);
    check("alu_wren", tRenRat_wrEn_OUT, 1);
    tick(); set_instr(1'b1, 1'b0, 1'b0); #1;
    check("alu_pushes", {tIQ_pushReq_OUT, tLSQ_pushReq_OUT, tROB_pushReq_OUT}, 3'b101);
    tick();
    check("alu_pushes_clear", {tIQ_pushReq_OUT, tLSQ_pushReq_OUT, tROB_pushReq_OUT}, 3'b000);

    // Load blocked by a full LSQ for five cycles.
    set_instr(1'b0, 1'b1, 1'b1); fLSQ_full_IN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; check($sformatf("lsq_stall_pop%0d", i), tQ_IDREN_popReq_OUT, 0);
      tick();
    end
    fLSQ_full_IN = 1'b0; #1;
    check("lsq_cause", tStallCause_OUT, 4'b0010);
    check("lsq_cycles", tStallCycles_OUT, 5);
    check("lsq_pop6", tQ_IDREN_popReq_OUT, 1);
    tick(); set_instr(1'b1, 1'b0, 1'b0); #1;
    check("lsq_pushes", {tIQ_pushReq_OUT, tLSQ_pushReq_OUT, tROB_pushReq_OUT}, 3'b011);
    check("lsq_cause_clear", tStallCause_OUT, 4'b0000);

    // Free list empty blocks only instructions that need a destination.
    set_instr(1'b0, 1'b0, 1'b1); fFreeL_empty_IN = 1'b1; #1;
    check("fl_stall_pop", tQ_IDREN_popReq_OUT, 0);
    check("fl_stall_flpop", tFreeL_popReq_OUT, 0);
    tick();
    check("fl_cause", tStallCause_OUT, 4'b1000);
    check("fl_cycles", tStallCycles_OUT, 6);
    fQ_IDREN_destReqd_IN = 1'b0; #1;
    check("nodest_pop", tQ_IDREN_popReq_OUT, 1);
    check("nodest_flpop", {tFreeL_popReq_OUT, tRenRat_wrEn_OUT}, 2'b00);
    tick(); fFreeL_empty_IN = 1'b0;
    set_instr(1'b0, 1'b0, 1'b1); FREEZE = 1'b1; #1;
    check("nodest_iqpush", tIQ_pushReq_OUT, 1);
    check("freeze_pop", tQ_IDREN_popReq_OUT, 0);
    fROB_full_IN = 1'b1;
    tick(); fROB_full_IN = 1'b0; FREEZE = 1'b0; #1;
    check("freeze_cause", tStallCause_OUT, 4'b0000);
    check("freeze_cycles", tStallCycles_OUT, 6);

    // Flush coincident with a dispatchable instruction; bits 0..31 mapped.
    fArchMapped_IN = {32'h0, 32'hFFFF_FFFF};
    fROB_flushReq_IN = 1'b1; #1;
    check("flush_beats_pop", tQ_IDREN_popReq_OUT, 0);
    tick(); fROB_flushReq_IN = 1'b0; #1;
    check("ratcopy_strobes", {tRenRatOverwrite_OUT, tFreeL_flush_OUT, tBusy_OUT}, 3'b111);
    check("ratcopy_nopush", {tFreeL_pushReq_OUT, tROB_pushReq_OUT}, 2'b00);
    n_acks = 0;
    for (int k = 2; k <= 66; k++) begin
      tick();
      fROB_flushReq_IN = (k == 20);
      #1;
      if (tROB_flushAck_OUT) n_acks++;
      if (k <= 64) begin
        check($sformatf("walk_push%0d", k - 1), tFreeL_pushReq_OUT, (k - 1) >= 32);
        check($sformatf("walk_data%0d", k - 1), tFreeL_pushData_OUT, ((k - 1) >= 32) ? (k - 1) : 0);
        check($sformatf("walk_pop%0d", k - 1), tQ_IDREN_popReq_OUT, 0);
      end else if (k == 65) begin
        check("ack_pulse", {tROB_flushAck_OUT, tBusy_OUT, tFreeL_pushReq_OUT}, 3'b110);
      end else begin
        check("post_ack", {tROB_flushAck_OUT, tBusy_OUT, tRenRatOverwrite_OUT}, 3'b000);
        check("post_ack_pop", tQ_IDREN_popReq_OUT, 1);
      end
    end
    fROB_flushReq_IN = 1'b0;
    tick(); set_instr(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (tROB_flushAck_OUT) n_acks++;
    end
    check("ack_count", n_acks, 1);

    // Reset in the middle of a rebuild walk with nothing mapped.
    fArchMapped_IN = '0;
    fROB_flushReq_IN = 1'b1;
    tick(); fROB_flushReq_IN = 1'b0;
    tick(); #1;
    check("walk_first", {tFreeL_pushReq_OUT, tFreeL_pushData_OUT}, {1'b1, 6'd1});
    for (int i = 0; i < 19; i++) tick();
    #1;
    check("walk_idx20", {tFreeL_pushReq_OUT, tFreeL_pushData_OUT}, {1'b1, 6'd20});
    RESET = 1'b0; #1;
    check("abort_outs", all_outs(), 64'h0);
    tick(); RESET = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      if (tROB_flushAck_OUT || tBusy_OUT || tFreeL_pushReq_OUT) n_acks++;
    end
    check("abort_no_ack", n_acks, 0);
    check("abort_cycles", tStallCycles_OUT, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
